l2_message_responder: RTL
=========================

# l2_message_responder

L2-side endpoint for the 62-bit L1→L2 message bus driven by the L1 instruction cache. It accepts messages through a valid/ready handshake and buffers them in a small FIFO. Each message is decoded into its command and address, and per-command statistics are kept. Every message is then answered on a response channel, with reads and read-for-ownership responses delayed by a programmable L2 access latency. It sits between the L1 cache's `L2message` output and the simulation's L2/memory model and statistics report.

## Interface
- `DEPTH`, 4 — message FIFO entries; power of two, ≥2.
- `READ_LATENCY`, 8 — cycles from pop to response for L2READ/L2READFOWN; ≥1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `msg_valid`  in  1  L1 presents a message.
- `msg`  in  62  [1:0] command, [61:2] 60-bit address.
- `msg_ready`  out  1  FIFO can accept; equals !full.
- `resp_valid`  out  1  response presented.
- `resp_cmd`  out  2  command being answered.
- `resp_address`  out  60  address being answered.
- `resp_owned`  out  1  1 only when answering L2READFOWN.
- `resp_ready`  in  1  consumer accepts response.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `cnt_return`, `cnt_write`, `cnt_read`, `cnt_rfo`  out  64 each  per-command message counts.

## Operation
- Command encoding: 0 RETURNDATA, 1 LWWRITE, 2 L2READ, 3 L2READFOWN.
- Push: `msg` is enqueued on any edge where `msg_valid && msg_ready`. Writing while full is impossible by construction, because `msg_ready` is low.
- FIFO: circular buffer with read/write pointers and an occupancy count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH. A push and a pop on the same edge leave the count unchanged.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the current-message registers and increment the matching counter. Commands 2/3 go to WAIT with the latency counter loaded to READ_LATENCY-1. Commands 0/1 go directly to RESP.
  - WAIT: if the latency counter is 0, go to RESP; otherwise decrement it.
  - RESP: `resp_valid`=1. The response fields come from the current-message registers and stay stable while `resp_valid && !resp_ready`. On `resp_ready`, go to IDLE.
- Exactly one message is in flight at a time. Responses are issued in arrival order.
- Counters increment by 1 on pop and wrap at 2^64. No saturation.
- `resp_owned` = (resp_cmd == 3) while `resp_valid`; it is 0 otherwise.

## Timing
- Reset values:
  - FIFO empty, `msg_ready`=1, `busy`=0.
  - `resp_valid`=0, `resp_cmd`=0, `resp_address`=0, `resp_owned`=0.
  - All counters 0, FSM IDLE.
- Reset asserted mid-operation discards all buffered and in-flight messages immediately. No response is completed.
- Message accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - Popped at E1.
  - Commands 0/1: `resp_valid` high after E1.
  - Commands 2/3: `resp_valid` high after E1+READ_LATENCY.
- Response consumed at edge Er (`resp_valid && resp_ready`): FSM is IDLE after Er, and the next FIFO entry pops at Er+1. Minimum spacing for back-to-back writes is therefore 2 cycles per message.
- Full FIFO with a pop at edge Ep: `msg_ready` rises after Ep, so the next push is possible at Ep+1.
- `busy` falls only in the cycle after the last response is consumed with the FIFO empty.

## Test plan
- Reset then idle: `msg_ready`=1, `resp_valid`=0, `busy`=0, all counters 0.
- Push LWWRITE at address 0x0000000000ABCDE with `resp_ready` held high:
  - `resp_valid` for exactly 1 cycle, 1 cycle after pop.
  - `resp_cmd`=1, `resp_address`=0xABCDE, `resp_owned`=0.
  - `cnt_write`=1.
- Push L2READFOWN at address 0x123 with READ_LATENCY=8:
  - `resp_valid` rises 8 cycles after pop.
  - `resp_owned`=1, `cnt_rfo`=1.
- Push 5 messages back-to-back with `resp_ready`=0 and DEPTH=4:
  - 4 accepted (the 5th is accepted only after the first pop frees a slot), then `msg_ready`=0.
  - The held response stays stable.
  - Releasing `resp_ready` drains all 5 in order, with counters matching the command mix.
- Assert `rst` during WAIT of an L2READ with 2 further entries queued:
  - All outputs return to reset values asynchronously.
  - No response is issued after release.
- Stream 1000 random commands with random `resp_ready`:
  - Response sequence equals input sequence.
  - The sum of the counters equals 1000.

Source files
------------

// File: rtl/l2_message_responder.sv
// L2-side endpoint for the L1->L2 message bus: buffers messages in a FIFO,
// counts them per command and answers each one, delaying reads by a latency.
module l2_message_responder #(
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msg_valid,
  input  logic [61:0] msg,
  output logic        msg_ready,
  output logic        resp_valid,
  output logic [1:0]  resp_cmd,
  output logic [59:0] resp_address,
  output logic        resp_owned,
  input  logic        resp_ready,
  output logic        busy,
  output logic [63:0] cnt_return,
  output logic [63:0] cnt_write,
  output logic [63:0] cnt_read,
  output logic [63:0] cnt_rfo
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int LW = $clog2(READ_LATENCY) + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [LW-1:0] LAT_INIT = LW'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [61:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]    cur_cmd;
  logic [59:0]   cur_addr;
  logic [LW-1:0] lat;

  logic          empty;
  logic          push;
  logic          pop;
  logic [61:0]   head;
  logic [1:0]    head_cmd;
  logic [59:0]   head_addr;
  logic [3:0]    cmd_hot;

  assign empty     = (count == '0);
  assign msg_ready = (count != FULL_CNT);
  assign push      = msg_valid && msg_ready;
  assign head      = mem[rd_ptr];
  assign head_cmd  = head[1:0];
  assign head_addr = head[61:2];
  assign cmd_hot   = 4'b0001 << head_cmd;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_n = head_cmd[1] ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (lat == '0) begin
          state_n = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pop        = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE:    pop = !empty;
      RESP:    resp_valid = 1'b1;
      default: begin end
    endcase
  end

  assign resp_cmd     = cur_cmd;
  assign resp_address = cur_addr;
  assign resp_owned   = resp_valid && (cur_cmd == 2'd3);
  assign busy         = !empty || (state != IDLE);

  // Storage array needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= msg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: begin end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_cmd  <= '0;
      cur_addr <= '0;
      lat      <= '0;
    end else begin
      if (pop) begin
        cur_cmd  <= head_cmd;
        cur_addr <= head_addr;
        lat      <= LAT_INIT;
      end else if (state == WAIT && lat != '0) begin
        lat <= lat - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_return <= '0;
      cnt_write  <= '0;
      cnt_read   <= '0;
      cnt_rfo    <= '0;
    end else if (pop) begin
      unique case (1'b1)
        cmd_hot[0]: cnt_return <= cnt_return + 64'd1;
        cmd_hot[1]: cnt_write  <= cnt_write + 64'd1;
        cmd_hot[2]: cnt_read   <= cnt_read + 64'd1;
        cmd_hot[3]: cnt_rfo    <= cnt_rfo + 64'd1;
        default:    begin end
      endcase
    end
  end

endmodule
